// File: rtl/regfile_write_arbiter.sv
// Two-port writeback arbiter in front of the 32x32 register file write port.
// Optional REGARB_CONFLICT_CNT_EN adds a saturating ConflictCount output.
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   ValidA,
    output logic                   ReadyA,
    input  logic [ADDR_W-1:0]      AddrA,
    input  logic [DATA_W-1:0]      DataA,
    input  logic                   ValidB,
    output logic                   ReadyB,
    input  logic [ADDR_W-1:0]      AddrB,
    input  logic [DATA_W-1:0]      DataB,
    output logic                   RegWrite,
    output logic [ADDR_W-1:0]      WriteRegister,
    output logic [DATA_W-1:0]      WriteData,
`ifdef REGARB_CONFLICT_CNT_EN
    output logic [15:0]            ConflictCount,
`endif
    output logic [2**ADDR_W-1:0]   Pending
);

    localparam int DEPTH = 2**ADDR_W;

    logic              held_a_q, held_a_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [DATA_W-1:0] data_a_q, data_a_d;
    logic              held_b_q, held_b_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic [DATA_W-1:0] data_b_q, data_b_d;
    logic              last_b_q, last_b_d;
    logic              wr_vld_q, wr_vld_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic grant_a, grant_b;
    logic xfer_a, xfer_b;

    // Round-robin: on conflict the port not granted last time wins.
    always_comb begin
        grant_a = held_a_q & (~held_b_q | last_b_q);
        grant_b = held_b_q & (~held_a_q | ~last_b_q);
    end

    assign ReadyA = ~held_a_q | grant_a;
    assign ReadyB = ~held_b_q | grant_b;
    assign xfer_a = ValidA & ReadyA;
    assign xfer_b = ValidB & ReadyB;

    // Next state of holding registers; address 0 writes are swallowed.
    always_comb begin
        held_a_d = held_a_q;
        addr_a_d = addr_a_q;
        data_a_d = data_a_q;
        held_b_d = held_b_q;
        addr_b_d = addr_b_q;
        data_b_d = data_b_q;
        if (xfer_a) begin
            held_a_d = (AddrA != '0);
            addr_a_d = AddrA;
            data_a_d = DataA;
        end else if (grant_a) begin
            held_a_d = 1'b0;
        end
        if (xfer_b) begin
            held_b_d = (AddrB != '0);
            addr_b_d = AddrB;
            data_b_d = DataB;
        end else if (grant_b) begin
            held_b_d = 1'b0;
        end
    end

    // Next state of the write stage and the round-robin pointer.
    always_comb begin
        wr_vld_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        last_b_d  = last_b_q;
        if (grant_a) begin
            wr_vld_d  = 1'b1;
            wr_addr_d = addr_a_q;
            wr_data_d = data_a_q;
            last_b_d  = 1'b0;
        end else if (grant_b) begin
            wr_vld_d  = 1'b1;
            wr_addr_d = addr_b_q;
            wr_data_d = data_b_q;
            last_b_d  = 1'b1;
        end
    end

    // State registers; reset discards everything in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            held_a_q  <= 1'b0;
            addr_a_q  <= '0;
            data_a_q  <= '0;
            held_b_q  <= 1'b0;
            addr_b_q  <= '0;
            data_b_q  <= '0;
            last_b_q  <= 1'b1;
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            held_a_q  <= held_a_d;
            addr_a_q  <= addr_a_d;
            data_a_q  <= data_a_d;
            held_b_q  <= held_b_d;
            addr_b_q  <= addr_b_d;
            data_b_q  <= data_b_d;
            last_b_q  <= last_b_d;
            wr_vld_q  <= wr_vld_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign RegWrite      = wr_vld_q;
    assign WriteRegister = wr_addr_q;
    assign WriteData     = wr_data_q;

    // Scoreboard of registers with a write held or in the write stage.
    always_comb begin
        Pending = '0;
        for (int r = 1; r < DEPTH; r++) begin
            Pending[r] = (held_a_q && addr_a_q == ADDR_W'(r))
                       | (held_b_q && addr_b_q == ADDR_W'(r))
                       | (wr_vld_q && wr_addr_q == ADDR_W'(r));
        end
    end

`ifdef REGARB_CONFLICT_CNT_EN
    logic [15:0] conf_cnt_q, conf_cnt_d;

    // Saturating count of cycles with both holding registers full.
    always_comb begin
        conf_cnt_d = conf_cnt_q;
        if (held_a_q && held_b_q && conf_cnt_q != 16'hFFFF)
            conf_cnt_d = conf_cnt_q + 16'd1;
    end

    // Conflict counter register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) conf_cnt_q <= '0;
        else          conf_cnt_q <= conf_cnt_d;
    end

    assign ConflictCount = conf_cnt_q;
`endif

endmodule
